// File: rtl/flow_sequencer_if.sv
// Program-load, run-control and status bundle for the flow sequencer.
// master = host/bench side, slave = sequencer side.
interface flow_sequencer_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 8
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              start;
  logic [N_CH-1:0]   pwm_out;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] pc_dbg;

  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  pwm_out, busy, done, error, pc_dbg
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output pwm_out, busy, done, error, pc_dbg
  );
endinterface

// File: rtl/flow_sequencer.sv
// Programmable valve sequencer: loadable instruction RAM, single counted loop,
// tick-based delays and N_CH PWM channels driven from per-channel duty registers.
module flow_sequencer #(
  parameter int N_CH      = 4,
  parameter int DUTY_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int TICK_DIV  = 100,
  parameter int PWM_PRESC = 1
) (
  input logic              clk,
  input logic              rst,
  flow_sequencer_if.slave  bus
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PSC_W  = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(PWM_PRESC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_DELAY, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_SETDUTY = 3'b001, OP_DELAY = 3'b010,
    OP_END = 3'b011, OP_LOOP = 3'b100
  } op_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [4:0]        loop_cnt, loop_cnt_d;
  logic              loop_active, loop_active_d;
  logic [TICK_W-1:0] tick, tick_d;
  logic [12:0]       dcnt, dcnt_d;
  logic              duty_we, adv;

  logic [15:0]       mem [DEPTH];
  logic [15:0]       ir;
  logic [DUTY_W-1:0] duty [N_CH];
  logic [PSC_W-1:0]  psc;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [N_CH-1:0]   pwm_d, pwm_q;
  logic              busy_q, done_q, error_q;

  op_t               op;
  logic [4:0]        f_hi;
  logic [7:0]        f_lo;
  logic              ch_bad, tgt_bad, writable;

  assign op       = op_t'(ir[15:13]);
  assign f_hi     = ir[12:8];
  assign f_lo     = ir[7:0];
  assign ch_bad   = {1'b0, f_hi} >= 6'(N_CH);
  assign tgt_bad  = (f_lo >> ADDR_W) != 8'd0;
  assign writable = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

  // NOTE: program RAM and instruction register carry no reset so the RAM
  // maps onto block memory and the loaded program survives rst.
  always_ff @(posedge clk) begin
    if (bus.prog_we && writable) mem[bus.prog_addr] <= bus.prog_data;
    ir <= mem[pc];
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    loop_cnt_d    = loop_cnt;
    loop_active_d = loop_active;
    tick_d        = tick;
    dcnt_d        = dcnt;
    duty_we       = 1'b0;
    adv           = 1'b0;
    unique case (state)
      S_IDLE: if (bus.start) begin
        state_d       = S_FETCH;
        pc_d          = '0;
        loop_active_d = 1'b0;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_NOP: adv = 1'b1;
          OP_SETDUTY: begin
            if (ch_bad) state_d = S_ERROR;
            else begin
              duty_we = 1'b1;
              adv     = 1'b1;
            end
          end
          OP_DELAY: begin
            if (ir[12:0] == 13'd0) adv = 1'b1;
            else begin
              tick_d  = TICK_LAST;
              dcnt_d  = ir[12:0];
              state_d = S_DELAY;
            end
          end
          OP_END: state_d = S_DONE;
          OP_LOOP: begin
            if (tgt_bad) state_d = S_ERROR;
            else if (!loop_active) begin
              if (f_hi == 5'd0) adv = 1'b1;
              else begin
                loop_cnt_d    = f_hi - 5'd1;
                loop_active_d = 1'b1;
                pc_d          = f_lo[ADDR_W-1:0];
                state_d       = S_FETCH;
              end
            end else if (loop_cnt == 5'd0) begin
              loop_active_d = 1'b0;
              adv           = 1'b1;
            end else begin
              loop_cnt_d = loop_cnt - 5'd1;
              pc_d       = f_lo[ADDR_W-1:0];
              state_d    = S_FETCH;
            end
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_DELAY: begin
        if (tick != '0) tick_d = tick - TICK_W'(1);
        else if (dcnt == 13'd1) adv = 1'b1;
        else begin
          dcnt_d = dcnt - 13'd1;
          tick_d = TICK_LAST;
        end
      end
      S_DONE, S_ERROR: if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Sequential fall-through never wraps past the last RAM word.
    if (adv) begin
      if (&pc) state_d = S_ERROR;
      else begin
        pc_d    = pc + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      loop_cnt    <= '0;
      loop_active <= 1'b0;
      tick        <= '0;
      dcnt        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      loop_cnt    <= loop_cnt_d;
      loop_active <= loop_active_d;
      tick        <= tick_d;
      dcnt        <= dcnt_d;
      busy_q      <= (state == S_FETCH) || (state == S_EXEC) || (state == S_DELAY);
      done_q      <= (state == S_DONE);
      error_q     <= (state == S_ERROR);
    end
  end

  // Valves fail closed: duties are held at zero for as long as ERROR lasts.
  always_ff @(posedge clk) begin
    if (rst || state == S_ERROR) begin
      for (int c = 0; c < N_CH; c++) duty[c] <= '0;
    end else if (duty_we) begin
      for (int c = 0; c < N_CH; c++)
        if (f_hi == 5'(c)) duty[c] <= f_lo[DUTY_W-1:0];
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int c = 0; c < N_CH; c++) pwm_d[c] = pwm_cnt < duty[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc     <= '0;
      pwm_cnt <= '0;
      pwm_q   <= '0;
    end else begin
      pwm_q <= pwm_d;
      if (psc == PSC_LAST) begin
        psc     <= '0;
        pwm_cnt <= pwm_cnt + DUTY_W'(1);
      end else begin
        psc <= psc + PSC_W'(1);
      end
    end
  end

  assign bus.pwm_out = pwm_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.pc_dbg  = pc;
endmodule

// File: tb/tb_flow_sequencer.sv
// Scoreboard bench: each run pushes its expected end condition; a monitor pops
// and compares whenever done or error rises. PWM and status checked inline.
module tb_flow_sequencer;
  localparam int N_CH     = 4;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int TICK_DIV = 4;

  typedef struct {
    string name;
    logic  err;
    int    pc;
    int    cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   first_seen[DEPTH];
  int   hi_cnt[N_CH];

  flow_sequencer_if #(.N_CH(N_CH), .ADDR_W(ADDR_W)) bus ();

  flow_sequencer #(
    .N_CH(N_CH), .DUTY_W(8), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .PWM_PRESC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int addr, input logic [15:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = ADDR_W'(addr);
    bus.prog_data = data;
    tick(1);
    bus.prog_we   = 1'b0;
  endtask

  task automatic expect_end(input string name, input logic err, input int pc, input int cycles);
    exp_t e;
    e.name = name; e.err = err; e.pc = pc; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  task automatic start_run();
    for (int i = 0; i < DEPTH; i++) first_seen[i] = -1;
    bus.start = 1'b1;
  endtask

  task automatic wait_end(input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (first_seen[bus.pc_dbg] < 0) first_seen[bus.pc_dbg] = cyc;
      if (bus.done || bus.error) begin
        hit = 1'b1;
        break;
      end
    end
    check({name, ".reached_end"}, 32'(hit), 32'd1);
  endtask

  task automatic stop_run(input string name);
    bus.start = 1'b0;
    tick(2);
    check({name, ".idle_busy"},  32'(bus.busy),  32'd0);
    check({name, ".idle_done"},  32'(bus.done),  32'd0);
    check({name, ".idle_error"}, 32'(bus.error), 32'd0);
  endtask

  task automatic pwm_window();
    for (int c = 0; c < N_CH; c++) hi_cnt[c] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) if (bus.pwm_out[c]) hi_cnt[c]++;
    end
  endtask

  // Monitor: measures run length from the busy rise to the done/error rise.
  initial begin
    bit busy_q = 1'b0, done_q = 1'b0, error_q = 1'b0;
    int t_busy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy && !busy_q) t_busy = cyc;
      if ((bus.done && !done_q) || (bus.error && !error_q)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_end: got done=%0b error=%0b, expected no completion",
                   bus.done, bus.error);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".error"},  32'(bus.error),  32'(e.err));
          check({e.name, ".pc"},     32'(bus.pc_dbg), 32'(e.pc));
          check({e.name, ".cycles"}, 32'(cyc - t_busy), 32'(e.cycles));
        end
      end
      busy_q  = bus.busy;
      done_q  = bus.done;
      error_q = bus.error;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;

    // Reset and idle
    tick(2);
    rst = 1'b0;
    check("reset.pwm",   32'(bus.pwm_out), 32'd0);
    check("reset.busy",  32'(bus.busy),    32'd0);
    check("reset.done",  32'(bus.done),    32'd0);
    check("reset.error", 32'(bus.error),   32'd0);
    check("reset.pc",    32'(bus.pc_dbg),  32'd0);
    write(0, 16'h2180);
    write(1, 16'h6000);
    tick(10);
    check("idle.busy", 32'(bus.busy),   32'd0);
    check("idle.pc",   32'(bus.pc_dbg), 32'd0);

    // Basic run: SETDUTY ch1=128, END
    expect_end("basic", 1'b0, 1, 4);
    start_run();
    tick(1);
    check("basic.busy_not_yet", 32'(bus.busy), 32'd0);
    tick(1);
    check("basic.busy_rise", 32'(bus.busy), 32'd1);
    wait_end("basic");
    tick(2);
    pwm_window();
    check("basic.pwm_ch0", 32'(hi_cnt[0]), 32'd0);
    check("basic.pwm_ch1", 32'(hi_cnt[1]), 32'd128);
    check("basic.pwm_ch2", 32'(hi_cnt[2]), 32'd0);
    check("basic.pwm_ch3", 32'(hi_cnt[3]), 32'd0);
    tick(5);
    check("basic.held_start_done", 32'(bus.done), 32'd1);
    stop_run("basic");

    // Delay timing: duty0 at pc 0, DELAY 3, duty1 at pc 2
    write(0, 16'h2040);
    write(1, 16'h4003);
    write(2, 16'h21FF);
    write(3, 16'h6000);
    expect_end("delay", 1'b0, 3, 20);
    start_run();
    wait_end("delay");
    check("delay.duty_gap", 32'(first_seen[3] - first_seen[1]), 32'd16);
    tick(2);
    pwm_window();
    check("delay.pwm_ch0", 32'(hi_cnt[0]), 32'd64);
    check("delay.pwm_ch1", 32'(hi_cnt[1]), 32'd255);
    check("delay.pwm_ch2", 32'(hi_cnt[2]), 32'd0);
    stop_run("delay");

    // Loop: body (DELAY 1 + LOOP) runs 3 times, 3*(6+2)+2
    write(0, 16'h4001);
    write(1, 16'h8200);
    write(2, 16'h6000);
    expect_end("loop", 1'b0, 2, 26);
    start_run();
    wait_end("loop");
    stop_run("loop");

    // Error: channel out of range, duties forced to zero
    write(0, 16'h2180);
    write(1, 16'h2540);
    expect_end("err_ch", 1'b1, 1, 4);
    start_run();
    wait_end("err_ch");
    tick(2);
    pwm_window();
    check("err_ch.pwm_ch0", 32'(hi_cnt[0]), 32'd0);
    check("err_ch.pwm_ch1", 32'(hi_cnt[1]), 32'd0);
    stop_run("err_ch");

    // Error: illegal opcode 111
    write(0, 16'hE000);
    expect_end("err_op", 1'b1, 0, 2);
    start_run();
    wait_end("err_op");
    stop_run("err_op");

    // Error: LOOP target above the address range
    write(0, 16'h8110);
    expect_end("err_tgt", 1'b1, 0, 2);
    start_run();
    wait_end("err_tgt");
    stop_run("err_tgt");

    // Error: fall-through off the last RAM word
    for (int i = 0; i < DEPTH; i++) write(i, 16'h0000);
    expect_end("err_fall", 1'b1, DEPTH - 1, 2 * DEPTH);
    start_run();
    wait_end("err_fall");
    stop_run("err_fall");

    // Write lockout during DELAY, verified by a second run
    write(0, 16'h4005);
    write(1, 16'h6000);
    expect_end("lockout", 1'b0, 1, 24);
    start_run();
    tick(8);
    write(1, 16'hE000);
    wait_end("lockout");
    stop_run("lockout");
    expect_end("lockout_rerun", 1'b0, 1, 24);
    start_run();
    wait_end("lockout_rerun");
    stop_run("lockout_rerun");

    // Reset mid-DELAY aborts; RAM keeps the program
    write(0, 16'h20FF);
    write(1, 16'h4005);
    write(2, 16'h6000);
    start_run();
    tick(12);
    check("abort.pre_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.start = 1'b0;
    tick(1);
    rst = 1'b0;
    check("abort.pwm",   32'(bus.pwm_out), 32'd0);
    check("abort.busy",  32'(bus.busy),    32'd0);
    check("abort.done",  32'(bus.done),    32'd0);
    check("abort.error", 32'(bus.error),   32'd0);
    check("abort.pc",    32'(bus.pc_dbg),  32'd0);
    pwm_window();
    check("abort.pwm_ch0", 32'(hi_cnt[0]), 32'd0);
    expect_end("abort_rerun", 1'b0, 2, 26);
    start_run();
    wait_end("abort_rerun");
    tick(2);
    pwm_window();
    check("abort_rerun.pwm_ch0", 32'(hi_cnt[0]), 32'd255);
    stop_run("abort_rerun");

    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
